// File: rtl/cpu_pkg.sv
// Shared types for the instruction fetch slice.
// Fetch FSM states, queue entry layouts and fixed constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        misalign;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        misalign;
    } pend_entry_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO used for both the pending-PC queue and the
// instruction output buffer; reads as zero while empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == CAP);
    assign count_o    = r_count;
    assign w_pop      = pop_i && !clr_i && !empty_o;
    assign w_push     = push_i && !clr_i && (!full_o || w_pop);
    assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage; contents are only visible once counted valid.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited requests to instruction memory,
// in-order response matching, stale-response flushing on redirect.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    output logic        pc_advance_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_misalign_o
);

    localparam int PEND_W = $bits(pend_entry_t);
    localparam int OUT_W  = $bits(fetch_entry_t);
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEPTH);

    fetch_state_e r_state;
    fetch_state_e w_state_nx;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] r_stale;
    logic [CNT_W-1:0] w_outst_nx;
    logic [CNT_W-1:0] w_stale_nx;

    logic [CNT_W:0]   w_inflight;
    logic             w_run;
    logic             w_redir;
    logic             w_accept;
    logic             w_rsp_ok;
    logic             w_rsp_stale;
    logic             w_rsp_live;

    pend_entry_t      w_pend_in;
    pend_entry_t      w_pend_head;
    logic             w_pend_empty;
    logic             w_pend_full;
    logic [CNT_W-1:0] w_pend_cnt;

    fetch_entry_t     w_out_in;
    fetch_entry_t     w_out_head;
    logic             w_out_empty;
    logic             w_out_full;
    logic             w_out_pop;
    logic [CNT_W-1:0] w_out_cnt;

    assign w_run      = (r_state == RUN);
    assign w_redir    = redirect_i && (r_state != IDLE);
    assign w_inflight = {1'b0, r_outst} + {1'b0, w_out_cnt};

    assign imem_req_valid_o = w_run && !redirect_i && (w_inflight < LIMIT);
    assign w_accept         = imem_req_valid_o && imem_req_ready_i;
    assign pc_advance_o     = w_accept;
    assign imem_req_addr_o  = word_addr(pc_i);

    // A response with nothing outstanding is ignored.
    assign w_rsp_ok    = imem_rsp_valid_i && (r_outst != '0);
    assign w_rsp_stale = w_rsp_ok && (r_stale != '0);
    assign w_rsp_live  = w_rsp_ok && (r_stale == '0) && !w_redir;

    assign w_pend_in.pc       = pc_i;
    assign w_pend_in.misalign = (pc_i[1:0] != 2'b00);

    assign w_out_in.pc       = w_pend_head.pc;
    assign w_out_in.misalign = w_pend_head.misalign;
    assign w_out_in.instr    = imem_rsp_data_i;

    assign instr_valid_o    = !w_out_empty;
    assign w_out_pop        = instr_valid_o && instr_ready_i && !w_redir;
    assign instr_o          = w_out_head.instr;
    assign instr_pc_o       = w_out_head.pc;
    assign instr_misalign_o = w_out_head.misalign;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PEND_W),
        .CNT_W (CNT_W)
    ) u_pend (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (w_redir),
        .push_i      (w_accept),
        .push_data_i (w_pend_in),
        .pop_i       (w_rsp_live),
        .pop_data_o  (w_pend_head),
        .empty_o     (w_pend_empty),
        .full_o      (w_pend_full),
        .count_o     (w_pend_cnt)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W),
        .CNT_W (CNT_W)
    ) u_out (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (w_redir),
        .push_i      (w_rsp_live),
        .push_data_i (w_out_in),
        .pop_i       (w_out_pop),
        .pop_data_o  (w_out_head),
        .empty_o     (w_out_empty),
        .full_o      (w_out_full),
        .count_o     (w_out_cnt)
    );

    // Outstanding/stale accounting; a redirect in RUN turns every
    // request still in flight (minus this cycle's response) stale.
    always_comb begin
        w_outst_nx = r_outst;
        w_stale_nx = r_stale;
        if (w_redir && w_run) begin
            w_stale_nx = r_outst - CNT_W'(w_rsp_ok);
            w_outst_nx = r_outst - CNT_W'(w_rsp_ok);
        end else begin
            if (w_rsp_stale)
                w_stale_nx = r_stale - CNT_W'(1);
            w_outst_nx = r_outst + CNT_W'(w_accept) - CNT_W'(w_rsp_ok);
        end
    end

    // Next-state logic for the fetch FSM.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    w_state_nx = RUN;
            RUN:     if (redirect_i && (w_stale_nx != '0))
                         w_state_nx = FLUSH;
            FLUSH:   if (w_stale_nx == '0)
                         w_state_nx = RUN;
            default: w_state_nx = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_outst <= '0;
            r_stale <= '0;
        end else begin
            r_state <= w_state_nx;
            r_outst <= w_outst_nx;
            r_stale <= w_stale_nx;
        end
    end

    a_rsp_no_outst: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(imem_rsp_valid_i && (r_outst == '0)));

    a_pend_track: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (r_stale == '0) |-> (w_pend_cnt == r_outst));

    a_live_has_pc: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        w_rsp_live |-> !w_pend_empty);

    a_pend_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        w_pend_full |-> !w_accept);

    a_out_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (w_out_full && w_rsp_live) |-> w_out_pop);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC register model and an
// in-order instruction memory model of configurable latency.
`timescale 1ns/1ps
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic        pc_advance_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b1;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_misalign_o;

    ifetch_unit #(.DEPTH(2), .CNT_W(2)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .pc_i             (pc_i),
        .redirect_i       (redirect_i),
        .pc_advance_o     (pc_advance_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_misalign_o (instr_misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mis;
    } dlv_t;

    mreq_t       mq[$];
    dlv_t        dq[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    int          first_acc = -1;
    int          first_val = -1;
    logic [31:0] pc_nx = 32'h0;
    logic [31:0] tgt = 32'h0;
    int          total = 0;
    int          bad = 0;

    // PC register, memory responder and delivery monitor.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            mq.delete();
            dq.delete();
            pc_i = 32'h0;
            pc_nx = 32'h0;
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i = 32'h0;
            cyc = 0;
            n_acc = 0;
            first_acc = -1;
            first_val = -1;
        end else begin
            cyc = cyc + 1;
            pc_i = pc_nx;
            #1;
            if (instr_valid_o && first_val < 0)
                first_val = cyc;
            if (instr_valid_o && instr_ready_i && !redirect_i)
                dq.push_back('{instr_pc_o, instr_o, instr_misalign_o});
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i = 32'h0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i = mq[0].addr ^ 32'hA5A5_0000;
                void'(mq.pop_front());
            end
            if (pc_advance_o) begin
                mq.push_back('{imem_req_addr_o, cyc + lat});
                n_acc = n_acc + 1;
                if (first_acc < 0)
                    first_acc = cyc;
            end
            if (redirect_i)
                pc_nx = tgt;
            else if (pc_advance_o)
                pc_nx = pc_i + 32'd4;
            else
                pc_nx = pc_i;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_accept(input string tag);
        int k;
        k = 0;
        while (pc_advance_o !== 1'b1 && k < 50) begin
            tick(1);
            k = k + 1;
        end
        chk(tag, {31'h0, pc_advance_o}, 32'h1);
    endtask

    task automatic wait_dq(input string tag, input int n);
        int k;
        k = 0;
        while (dq.size() < n && k < 200) begin
            tick(1);
            k = k + 1;
        end
        chk(tag, (dq.size() >= n) ? 32'h1 : 32'h0, 32'h1);
    endtask

    task automatic chk_dq(input string tag, input int i,
                          input logic [31:0] pc, input logic mis);
        if (dq.size() > i) begin
            chk({tag, "_pc"}, dq[i].pc, pc);
            chk({tag, "_ins"}, dq[i].ins, {pc[31:2], 2'b00} ^ 32'hA5A5_0000);
            chk({tag, "_mis"}, {31'h0, dq[i].mis}, {31'h0, mis});
        end else begin
            chk({tag, "_missing"}, dq.size(), i + 1);
        end
    endtask

    task automatic do_reset(input int l);
        rst_n_i = 1'b0;
        redirect_i = 1'b0;
        lat = l;
        tick(2);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, asserted asynchronously before any clock edge.
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        chk("rst_pc_adv", {31'h0, pc_advance_o}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_misalign", {31'h0, instr_misalign_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        tick(2);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));

        // Straight-line fetch, 1-cycle memory, decode always ready.
        lat = 1;
        rst_n_i = 1'b1;
        chk("idle_no_req", {31'h0, imem_req_valid_o}, 32'h0);
        wait_accept("t1_accept");
        wait_dq("t1_dq", 3);
        chk("t1_latency", first_val - first_acc, 32'd2);
        chk_dq("t1_d0", 0, 32'h0, 1'b0);
        chk_dq("t1_d1", 1, 32'h4, 1'b0);
        chk_dq("t1_d2", 2, 32'h8, 1'b0);

        // Decode stalled: two requests fill the credits, head held.
        instr_ready_i = 1'b0;
        do_reset(1);
        tick(6);
        chk("t2_acc_cnt", n_acc, 32'd2);
        chk("t2_req_valid", {31'h0, imem_req_valid_o}, 32'h0);
        chk("t2_pc_adv", {31'h0, pc_advance_o}, 32'h0);
        chk("t2_valid", {31'h0, instr_valid_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_pc", instr_pc_o, 32'h0);
            chk("t2_hold_ins", instr_o, 32'hA5A5_0000);
            tick(1);
        end
        instr_ready_i = 1'b1;
        wait_dq("t2_dq", 4);
        chk_dq("t2_d0", 0, 32'h0, 1'b0);
        chk_dq("t2_d1", 1, 32'h4, 1'b0);
        chk_dq("t2_d2", 2, 32'h8, 1'b0);
        chk_dq("t2_d3", 3, 32'hC, 1'b0);

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset(3);
        wait_accept("t3_accept");
        tick(2);
        dq.delete();
        redirect_i = 1'b1;
        tgt = 32'h100;
        #1;
        chk("t3_no_req", {31'h0, imem_req_valid_o}, 32'h0);
        tick(1);
        redirect_i = 1'b0;
        chk("t3_flush", 32'(dut.r_state), 32'(FLUSH));
        chk("t3_stale2", 32'(dut.r_stale), 32'd2);
        tick(1);
        chk("t3_flush2", 32'(dut.r_state), 32'(FLUSH));
        chk("t3_stale1", 32'(dut.r_stale), 32'd1);
        tick(1);
        chk("t3_run", 32'(dut.r_state), 32'(RUN));
        wait_dq("t3_dq", 2);
        chk_dq("t3_d0", 0, 32'h100, 1'b0);
        chk_dq("t3_d1", 1, 32'h104, 1'b0);

        // Redirect in the same cycle a response arrives.
        do_reset(2);
        wait_accept("t4_accept");
        tick(2);
        dq.delete();
        redirect_i = 1'b1;
        tgt = 32'h200;
        tick(1);
        redirect_i = 1'b0;
        chk("t4_flush", 32'(dut.r_state), 32'(FLUSH));
        chk("t4_stale1", 32'(dut.r_stale), 32'd1);
        tick(1);
        chk("t4_run", 32'(dut.r_state), 32'(RUN));
        wait_dq("t4_dq", 1);
        chk_dq("t4_d0", 0, 32'h200, 1'b0);

        // Memory ready toggling 1-0-1, 3-cycle memory.
        do_reset(3);
        for (int k = 0; k < 30; k++) begin
            imem_req_ready_i = ((k % 3) != 1);
            #1;
            if (!imem_req_ready_i)
                chk("t5_no_adv", {31'h0, pc_advance_o}, 32'h0);
            tick(1);
        end
        imem_req_ready_i = 1'b1;
        wait_dq("t5_dq", 6);
        for (int i = 0; i < 6; i++)
            chk_dq("t5_seq", i, 32'(4 * i), 1'b0);

        // Misaligned PC loaded while IDLE (no flush), then reset mid-run.
        do_reset(1);
        redirect_i = 1'b1;
        tgt = 32'h102;
        tick(1);
        redirect_i = 1'b0;
        chk("t6_idle_redir", 32'(dut.r_state), 32'(RUN));
        wait_dq("t6_dq", 2);
        chk_dq("t6_d0", 0, 32'h102, 1'b1);
        chk_dq("t6_d1", 1, 32'h106, 1'b1);
        tick(1);
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_req", {31'h0, imem_req_valid_o}, 32'h0);
        chk("t6_rst_adv", {31'h0, pc_advance_o}, 32'h0);
        chk("t6_rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t6_rst_mis", {31'h0, instr_misalign_o}, 32'h0);
        chk("t6_rst_ins", instr_o, 32'h0);
        chk("t6_rst_pc", instr_pc_o, 32'h0);
        tick(2);
        rst_n_i = 1'b1;
        wait_dq("t6_restart_dq", 1);
        chk_dq("t6_restart", 0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
